// File: rtl/alu_pkg.sv
// Opcode encodings and request/response types shared by the ALU share arbiter.
package alu_pkg;

    localparam int OP_W     = 4;
    localparam int ID_MAX_W = 3;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [31:0]     src1;
        logic [31:0]     src2;
    } alu_req_t;

    // id is sized for the largest supported requester count (8)
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [31:0]         result;
        logic                ovf;
    } alu_resp_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester/consumer bundle of alu_share_arbiter.
// Defining ALU_ARB_OVF_EN adds resp_ovf and ovf_sticky.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int CNT_W   = 16
);
    import alu_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*OP_W-1:0]  req_op;
    logic [NUM_REQ*32-1:0]    req_src1;
    logic [NUM_REQ*32-1:0]    req_src2;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [31:0]              resp_result;
    logic [NUM_REQ*CNT_W-1:0] acc_cnt;
`ifdef ALU_ARB_OVF_EN
    logic                     resp_ovf;
    logic [NUM_REQ-1:0]       ovf_sticky;
`endif

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
`ifdef ALU_ARB_OVF_EN
        input  resp_ovf, ovf_sticky,
`endif
        input  req_ready, resp_valid, resp_id, resp_result, acc_cnt
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
`ifdef ALU_ARB_OVF_EN
        output resp_ovf, ovf_sticky,
`endif
        output req_ready, resp_valid, resp_id, resp_result, acc_cnt
    );

endinterface

// File: rtl/alu_core.sv
// 32-bit integer ALU; output is forced to zero while not enabled.
module alu_core
    import alu_pkg::*;
(
    input  logic        enable,
    input  alu_req_t    req,
    output logic [31:0] result,
    output logic        overflow
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = req.src1 + req.src2;
    assign diff = req.src1 - req.src2;

    // Only ADD and SUB report signed overflow; unknown opcodes give zero
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        if (enable) begin
            case (req.op)
                ALU_ADD: begin
                    result   = sum;
                    overflow = (req.src1[31] == req.src2[31]) && (sum[31] != req.src1[31]);
                end
                ALU_SUB: begin
                    result   = diff;
                    overflow = (req.src1[31] != req.src2[31]) && (diff[31] != req.src1[31]);
                end
                ALU_AND:  result = req.src1 & req.src2;
                ALU_OR:   result = req.src1 | req.src2;
                ALU_XOR:  result = req.src1 ^ req.src2;
                ALU_SLL:  result = req.src1 << req.src2[4:0];
                ALU_SRL:  result = req.src1 >> req.src2[4:0];
                ALU_SRA:  result = $unsigned($signed(req.src1) >>> req.src2[4:0]);
                ALU_SLT:  result = {31'b0, $signed(req.src1) < $signed(req.src2)};
                ALU_SLTU: result = {31'b0, req.src1 < req.src2};
                default:  result = '0;
            endcase
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    // idx is valid whenever any request is present; grant additionally needs en
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        grant[idx] = en && found;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters with a one-entry response slot.
// Defining ALU_ARB_OVF_EN exports the overflow flag and per-requester sticky overflow bits.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]                    state_q;
    logic [0:0]                    state_d;
    logic [ID_W-1:0]               rr_ptr;
    logic [ID_W-1:0]               grant_idx;
    logic [ID_W-1:0]               ptr_next;
    logic [NUM_REQ-1:0]            grant;
    logic                          can_accept;
    logic                          accept;
    alu_req_t                      sel_req;
    alu_resp_t                     slot_q;
    logic [31:0]                   alu_result;
    logic                          alu_ovf;
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;
    logic                          unused_bits;

    assign can_accept = (state_q == S_EMPTY) || bus.resp_ready;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_arb (
        .req  (bus.req_valid),
        .ptr  (rr_ptr),
        .en   (can_accept),
        .grant(grant),
        .idx  (grant_idx)
    );

    assign accept        = |grant;
    assign bus.req_ready = grant;
    assign ptr_next      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign sel_req = '{
        op:   bus.req_op[int'(grant_idx) * OP_W +: OP_W],
        src1: bus.req_src1[int'(grant_idx) * 32 +: 32],
        src2: bus.req_src2[int'(grant_idx) * 32 +: 32]
    };

    alu_core u_alu (
        .enable  (accept),
        .req     (sel_req),
        .result  (alu_result),
        .overflow(alu_ovf)
    );

    // An accept always refills the slot, even when the old entry leaves this cycle
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = S_FULL;
        end else if (bus.resp_ready) begin
            state_d = S_EMPTY;
        end
    end

`ifdef ALU_ARB_OVF_EN
    logic [NUM_REQ-1:0] sticky_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            slot_q  <= '0;
            rr_ptr  <= '0;
            cnt_q   <= '0;
`ifdef ALU_ARB_OVF_EN
            sticky_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                slot_q <= '{id: ID_MAX_W'(grant_idx), result: alu_result, ovf: alu_ovf};
                rr_ptr <= ptr_next;
                if (cnt_q[grant_idx] != '1) begin
                    cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
                end
`ifdef ALU_ARB_OVF_EN
                if (alu_ovf) begin
                    sticky_q[grant_idx] <= 1'b1;
                end
`endif
            end
        end
    end

    assign bus.resp_valid  = (state_q == S_FULL);
    assign bus.resp_id     = slot_q.id[ID_W-1:0];
    assign bus.resp_result = slot_q.result;
    assign bus.acc_cnt     = cnt_q;

`ifdef ALU_ARB_OVF_EN
    assign bus.resp_ovf   = slot_q.ovf;
    assign bus.ovf_sticky = sticky_q;
`endif

    // Upper id bits, and the overflow path when it is not exported, have no reader
    assign unused_bits = ^{slot_q.id, slot_q.ovf, alu_ovf};

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scoreboard bench for alu_share_arbiter (two requesters, 2-bit counters).
// Overflow checks are compiled in when ALU_ARB_OVF_EN is defined.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int CNT_W   = 2;

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    alu_share_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One vector per clock: drive after the edge, check ready, queue the expected result
    task automatic applyStimulus(
        input logic [1:0]  valid,
        input logic [3:0]  op0,
        input logic [31:0] a0,
        input logic [31:0] b0,
        input logic [3:0]  op1,
        input logic [31:0] a1,
        input logic [31:0] b1,
        input logic        rr,
        input logic [1:0]  exp_ready,
        input logic [31:0] exp_result,
        input logic        exp_ovf
    );
        exp_t e;
        @(posedge clk);
        #2;
        bus.req_valid  = valid;
        bus.req_op     = {op1, op0};
        bus.req_src1   = {a1, a0};
        bus.req_src2   = {b1, b0};
        bus.resp_ready = rr;
        #1;
        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (exp_ready != 2'b00) begin
            e.id     = exp_ready[1];
            e.result = exp_result;
            e.ovf    = exp_ovf;
            exp_q.push_back(e);
        end
    endtask

    task automatic idleCycle(input logic rr);
        applyStimulus(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, rr, 2'b00, 32'd0, 1'b0);
    endtask

    task automatic checkCounts(input int e0, input int e1);
        checkOutput("acc_cnt0", 32'(bus.acc_cnt[1:0]), e0);
        checkOutput("acc_cnt1", 32'(bus.acc_cnt[3:2]), e1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("rst_resp_id", 32'(bus.resp_id), 32'd0);
        checkOutput("rst_resp_result", bus.resp_result, 32'd0);
        checkOutput("rst_acc_cnt", 32'(bus.acc_cnt), 32'd0);
`ifdef ALU_ARB_OVF_EN
        checkOutput("rst_ovf_sticky", 32'(bus.ovf_sticky), 32'd0);
`endif
    endtask

    // Monitor: compare the head of the scoreboard whenever a response is presented
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL resp_unexpected: got id %0d result 0x%0h, expected no response",
                             bus.resp_id, bus.resp_result);
                end else begin
                    checkOutput("resp_id", 32'(bus.resp_id), 32'(exp_q[0].id));
                    checkOutput("resp_result", bus.resp_result, exp_q[0].result);
`ifdef ALU_ARB_OVF_EN
                    checkOutput("resp_ovf", 32'(bus.resp_ovf), 32'(exp_q[0].ovf));
`endif
                    if (bus.resp_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout at %0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_op     = '0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.resp_ready = 1'b0;
        doReset();

        $display("[TB] single op");
        applyStimulus(2'b01, ALU_ADD, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 32'd12, 1'b0);
        idleCycle(1'b1);
        checkOutput("resp_valid_latency", 32'(bus.resp_valid), 32'd1);
        idleCycle(1'b1);
        checkOutput("resp_valid_drain", 32'(bus.resp_valid), 32'd0);
        checkCounts(1, 0);

        $display("[TB] contention");
        doReset();
        applyStimulus(2'b11, ALU_ADD, 32'd1, 32'd2, ALU_SUB, 32'd10, 32'd3, 1'b1, 2'b01, 32'd3, 1'b0);
        applyStimulus(2'b11, ALU_ADD, 32'd100, 32'd200, ALU_SUB, 32'd10, 32'd3, 1'b1, 2'b10, 32'd7, 1'b0);
        applyStimulus(2'b11, ALU_ADD, 32'd100, 32'd200, ALU_XOR, 32'hF0F0, 32'h0FF0, 1'b1, 2'b01, 32'd300, 1'b0);
        applyStimulus(2'b11, ALU_AND, 32'hFF, 32'h0F, ALU_XOR, 32'hF0F0, 32'h0FF0, 1'b1, 2'b10, 32'hFF00, 1'b0);
        idleCycle(1'b1);
        checkCounts(2, 2);

        $display("[TB] backpressure");
        applyStimulus(2'b01, ALU_OR, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 32'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b01, ALU_ADD, 32'd8, 32'd8, ALU_ADD, 32'd0, 32'd0, 1'b0, 2'b00, 32'd0, 1'b0);
        end
        applyStimulus(2'b01, ALU_ADD, 32'd8, 32'd8, ALU_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 32'd16, 1'b0);
        idleCycle(1'b1);
        checkCounts(3, 2);

        $display("[TB] wrap and pointer");
        applyStimulus(2'b01, ALU_ADD, 32'd2, 32'd2, ALU_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 32'd4, 1'b0);
        applyStimulus(2'b10, ALU_ADD, 32'd0, 32'd0, ALU_SUB, 32'd0, 32'd1, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(2'b01, 4'hF, 32'd5, 32'd5, ALU_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 32'd0, 1'b0);
        applyStimulus(2'b11, ALU_ADD, 32'd1, 32'd1, ALU_SLL, 32'd1, 32'd4, 1'b1, 2'b10, 32'd16, 1'b0);
        applyStimulus(2'b01, ALU_ADD, 32'd1, 32'd1, ALU_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 32'd2, 1'b0);
        idleCycle(1'b1);
        checkCounts(3, 3);

        $display("[TB] overflow");
        applyStimulus(2'b10, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1, 2'b10, 32'h8000_0000, 1'b1);
        idleCycle(1'b1);
`ifdef ALU_ARB_OVF_EN
        checkOutput("ovf_sticky_add", 32'(bus.ovf_sticky), 32'b10);
`endif
        applyStimulus(2'b01, ALU_SUB, 32'h8000_0000, 32'd1, ALU_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 32'h7FFF_FFFF, 1'b1);
        idleCycle(1'b1);
`ifdef ALU_ARB_OVF_EN
        checkOutput("ovf_sticky_sub", 32'(bus.ovf_sticky), 32'b11);
`endif

        $display("[TB] reset with held response, counter saturation");
        applyStimulus(2'b01, ALU_ADD, 32'd3, 32'd4, ALU_ADD, 32'd0, 32'd0, 1'b0, 2'b01, 32'd7, 1'b0);
        idleCycle(1'b0);
        checkOutput("held_resp_valid", 32'(bus.resp_valid), 32'd1);
        doReset();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(2'b01, ALU_ADD, 32'(i), 32'd1, ALU_ADD, 32'd0, 32'd0, 1'b1, 2'b01, 32'(i + 1), 1'b0);
            idleCycle(1'b1);
            checkCounts((i < 3) ? i : 3, 0);
        end

        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
